// File: rtl/clk_ui_pkg.sv
// Shared types and helpers for the clock user-interface front end:
// edit FSM state encoding, BCD field limits, edit_field one-hot codes
// and saturating-free wrap-around BCD stepping.
package clk_ui_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_T_HR     = 3'd1,
    ST_T_MIN    = 3'd2,
    ST_T_SEC    = 3'd3,
    ST_T_COMMIT = 3'd4,
    ST_A_HR     = 3'd5,
    ST_A_MIN    = 3'd6,
    ST_A_COMMIT = 3'd7
  } state_t;

  localparam logic [7:0] HR_MAX = 8'h23;
  localparam logic [7:0] MS_MAX = 8'h59;

  localparam logic [2:0] FIELD_NONE = 3'b000;
  localparam logic [2:0] FIELD_HR   = 3'b100;
  localparam logic [2:0] FIELD_MIN  = 3'b010;
  localparam logic [2:0] FIELD_SEC  = 3'b001;

  // One BCD step up or down with wrap at 00/max; no step when up and dn
  // are both set or both clear.
  function automatic logic [7:0] bcd_step(input logic [7:0] v,
                                          input logic [7:0] max,
                                          input logic       up,
                                          input logic       dn);
    logic [7:0] r;
    r = v;
    if (up && !dn) begin
      if (v == max)             r = 8'h00;
      else if (v[3:0] == 4'h9)  r = {v[7:4] + 4'h1, 4'h0};
      else                      r = v + 8'h01;
    end else if (dn && !up) begin
      if (v == 8'h00)           r = max;
      else if (v[3:0] == 4'h0)  r = {v[7:4] - 4'h1, 4'h9};
      else                      r = v - 8'h01;
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button debouncer: two-flop synchronizer followed by a stability
// counter. The output level follows the synchronized input only after it
// has differed from the current level for DEBOUNCE_CYCLES consecutive cycles.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_sync1;
  logic          r_sync2;
  logic          r_level;
  logic [CW-1:0] r_cnt;

  // Bring the asynchronous button into the clock domain.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Accept a level change only after it has been stable long enough.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else if (r_sync2 == r_level) begin
      r_cnt <= '0;
    end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      r_level <= r_sync2;
      r_cnt   <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_level = r_level;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven time/alarm setting front end. Four debounced buttons drive
// an edit FSM that steps through BCD fields and commits with stretched
// strobes long enough for the 1 Hz logic to sample.
// Optional build macro EDIT_TIMEOUT_EN: abort an idle edit after
// TIMEOUT_CYCLES (alarm registers revert to the last committed alarm).
module time_set_ctrl
  import clk_ui_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 1_000_000,
  parameter int LOAD_HOLD_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES   = 500_000_000
) (
  input  logic       clk_50Mhz,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_alarm,
  input  logic       btn_inc,
  input  logic       btn_dec,
  input  logic [7:0] cur_hours,
  input  logic [7:0] cur_minutes,
  input  logic [7:0] cur_seconds,
  output logic       load_time,
  output logic [7:0] load_hours,
  output logic [7:0] load_minutes,
  output logic [7:0] load_seconds,
  output logic       set_alarm_enable,
  output logic [7:0] set_alarm_hours,
  output logic [7:0] set_alarm_minutes,
  output logic [2:0] edit_field,
  output logic       alarm_mode
);

  localparam int HOLD_W = (LOAD_HOLD_CYCLES > 1) ? $clog2(LOAD_HOLD_CYCLES) : 1;

  if (DEBOUNCE_CYCLES < 1 || LOAD_HOLD_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("time_set_ctrl: cycle parameters must be at least 1");
  end

  logic [3:0]        w_raw;
  logic [3:0]        w_level;
  logic [3:0]        r_level_d;
  logic [3:0]        w_press;
  logic              w_mode;
  logic              w_alarm;
  logic              w_up;
  logic              w_dn;
  state_t            r_state;
  logic [7:0]        r_ld_h, r_ld_m, r_ld_s;
  logic [7:0]        r_al_h, r_al_m;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic              w_hold_done;

  assign w_raw = {btn_dec, btn_inc, btn_alarm, btn_mode};

  for (genvar i = 0; i < 4; i++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk     (clk_50Mhz),
      .rst_n   (reset),
      .i_raw   (w_raw[i]),
      .o_level (w_level[i])
    );
  end

  // Delay debounced levels by one cycle to turn each press into a 1-cycle pulse.
  // NOTE: the reset branch is asynchronous so strobes drop the instant reset asserts, not at the next edge.
  always_ff @(posedge clk_50Mhz or negedge reset) begin
    if (!reset) r_level_d <= '0;
    else        r_level_d <= w_level;
  end

  assign w_press = w_level & ~r_level_d;
  assign w_mode  = w_press[0];
  assign w_alarm = w_press[1];
  // inc and dec together cancel each other.
  assign w_up    = w_press[2] & ~w_press[3];
  assign w_dn    = w_press[3] & ~w_press[2];

  assign w_hold_done = (r_hold_cnt == HOLD_W'(LOAD_HOLD_CYCLES - 1));

`ifdef EDIT_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TO_W-1:0] r_to_cnt;
  logic [7:0]      r_al_cmt_h, r_al_cmt_m;
  logic            w_time_edit, w_alarm_edit, w_acted, w_timeout;

  assign w_time_edit  = (r_state == ST_T_HR) || (r_state == ST_T_MIN) || (r_state == ST_T_SEC);
  assign w_alarm_edit = (r_state == ST_A_HR) || (r_state == ST_A_MIN);
  assign w_acted      = (w_time_edit  && (w_mode  || w_up || w_dn)) ||
                        (w_alarm_edit && (w_alarm || w_up || w_dn));
  assign w_timeout    = (w_time_edit || w_alarm_edit) && !w_acted &&
                        (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Idle counter: held at zero outside edit states and restarted by any acted-on press.
  always_ff @(posedge clk_50Mhz or negedge reset) begin
    if (!reset)                                      r_to_cnt <= '0;
    else if (!(w_time_edit || w_alarm_edit) || w_acted) r_to_cnt <= '0;
    else                                             r_to_cnt <= r_to_cnt + TO_W'(1);
  end
`endif

  // Edit FSM together with the field registers it owns.
  always_ff @(posedge clk_50Mhz or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_ld_h     <= 8'h00;
      r_ld_m     <= 8'h00;
      r_ld_s     <= 8'h00;
      r_al_h     <= 8'h00;
      r_al_m     <= 8'h00;
      r_hold_cnt <= '0;
`ifdef EDIT_TIMEOUT_EN
      r_al_cmt_h <= 8'h00;
      r_al_cmt_m <= 8'h00;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_hold_cnt <= '0;
          if (w_mode) begin
            r_ld_h  <= cur_hours;
            r_ld_m  <= cur_minutes;
            r_ld_s  <= cur_seconds;
            r_state <= ST_T_HR;
          end else if (w_alarm) begin
            r_state <= ST_A_HR;
          end
        end
        ST_T_HR: begin
          if (w_mode) r_state <= ST_T_MIN;
          else        r_ld_h  <= bcd_step(r_ld_h, HR_MAX, w_up, w_dn);
        end
        ST_T_MIN: begin
          if (w_mode) r_state <= ST_T_SEC;
          else        r_ld_m  <= bcd_step(r_ld_m, MS_MAX, w_up, w_dn);
        end
        ST_T_SEC: begin
          if (w_mode) r_state <= ST_T_COMMIT;
          else        r_ld_s  <= bcd_step(r_ld_s, MS_MAX, w_up, w_dn);
        end
        ST_A_HR: begin
          if (w_alarm) r_state <= ST_A_MIN;
          else         r_al_h  <= bcd_step(r_al_h, HR_MAX, w_up, w_dn);
        end
        ST_A_MIN: begin
          if (w_alarm) begin
            r_state <= ST_A_COMMIT;
`ifdef EDIT_TIMEOUT_EN
            r_al_cmt_h <= r_al_h;
            r_al_cmt_m <= r_al_m;
`endif
          end else begin
            r_al_m <= bcd_step(r_al_m, MS_MAX, w_up, w_dn);
          end
        end
        ST_T_COMMIT, ST_A_COMMIT: begin
          if (w_hold_done) begin
            r_hold_cnt <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_hold_cnt <= r_hold_cnt + HOLD_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
`ifdef EDIT_TIMEOUT_EN
      // An abort overrides whatever the case above decided this cycle.
      if (w_timeout) begin
        r_state <= ST_IDLE;
        if (w_alarm_edit) begin
          r_al_h <= r_al_cmt_h;
          r_al_m <= r_al_cmt_m;
        end
      end
`endif
    end
  end

  // Decode field indicator and alarm-mode flag from the state.
  // NOTE: defaults come first so no path through the case can infer a latch.
  always_comb begin
    edit_field = FIELD_NONE;
    alarm_mode = 1'b0;
    case (r_state)
      ST_T_HR:  edit_field = FIELD_HR;
      ST_T_MIN: edit_field = FIELD_MIN;
      ST_T_SEC: edit_field = FIELD_SEC;
      ST_A_HR:  begin edit_field = FIELD_HR;  alarm_mode = 1'b1; end
      ST_A_MIN: begin edit_field = FIELD_MIN; alarm_mode = 1'b1; end
      default:  ;
    endcase
  end

  assign load_time         = (r_state == ST_T_COMMIT);
  assign set_alarm_enable  = (r_state == ST_A_COMMIT);
  assign load_hours        = r_ld_h;
  assign load_minutes      = r_ld_m;
  assign load_seconds      = r_ld_s;
  assign set_alarm_hours   = r_al_h;
  assign set_alarm_minutes = r_al_m;

endmodule
